sha_256_pad: RTL and testbench

- Message pre-processor and block feeder for the SHA-256 core.
- Accepts a byte stream through a valid/ready handshake.
- Packs bytes big-endian into 32-bit words and applies FIPS 180-4 padding: the 0x80 marker, zero fill, and the 64-bit bit-length.
- Presents complete 16-word blocks, held stable until the consumer takes them; drives the core's m_i block input.

---
 rtl/sha_256_pad.sv | 132 +++++++++++++
 tb/tb_sha_256_pad.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sha_256_pad.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with the 0x80 marker,
// zero fill and 64-bit bit-length. Define SHA_PAD_BLKCNT_EN to add the blk_cnt_o block counter.
module sha_256_pad #(
  parameter int n     = 32,
  parameter int m     = 16,
  parameter int LEN_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  output logic [n-1:0]       blk_o [0:m-1],
  output logic               blk_valid_o,
  output logic               blk_last_o,
  input  logic               blk_ready_i
`ifdef SHA_PAD_BLKCNT_EN
  , output logic [15:0]      blk_cnt_o
`endif
);
  localparam int NB = n * m / 8;
  localparam int WB = n / 8;
  localparam int IW = $clog2(NB);
  localparam logic [IW:0]   LEN_IDX = (IW+1)'(NB - 8);
  localparam logic [IW-1:0] IDX_MAX = IW'(NB - 1);

  typedef enum logic [2:0] {S_LOAD, S_PAD, S_LEN, S_OUT, S_OUT_LAST} state_t;

  state_t                 state;
  logic [0:NB-1][7:0]     buf_q;
  logic [IW-1:0]          idx;
  logic [IW:0]            idx_inc;
  logic [LEN_W-1:0]       len;
  logic                   pad_pending, len_pending, wrapped;

  assign idx_inc = {1'b0, idx} + 1'b1;

  // Ascending packed buffer: the slice MSB is the lowest byte index, giving big-endian words.
  for (genvar w = 0; w < m; w++) begin : g_word
    assign blk_o[w] = buf_q[WB*w +: WB];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_LOAD;
      buf_q       <= '0;
      idx         <= '0;
      len         <= '0;
      pad_pending <= 1'b0;
      len_pending <= 1'b0;
      wrapped     <= 1'b0;
      in_ready_o  <= 1'b1;
      blk_valid_o <= 1'b0;
      blk_last_o  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (in_valid_i) begin
          buf_q[idx] <= in_data_i;
          idx        <= idx + 1'b1;
          len        <= len + LEN_W'(8);
          if (in_last_i) begin
            state      <= S_PAD;
            in_ready_o <= 1'b0;
            wrapped    <= (idx == IDX_MAX);
          end else if (idx == IDX_MAX) begin
            state       <= S_OUT;
            in_ready_o  <= 1'b0;
            blk_valid_o <= 1'b1;
          end
        end
        S_PAD: begin
          // A message ending on byte 63 leaves no room: the marker moves to the next block.
          if (wrapped) begin
            state       <= S_OUT;
            pad_pending <= 1'b1;
            blk_valid_o <= 1'b1;
          end else begin
            buf_q[idx] <= 8'h80;
            idx        <= idx + 1'b1;
            if (idx_inc <= LEN_IDX) begin
              state <= S_LEN;
            end else begin
              state       <= S_OUT;
              len_pending <= 1'b1;
              blk_valid_o <= 1'b1;
            end
          end
        end
        S_LEN: begin
          buf_q[NB-8 +: 8] <= len;
          state            <= S_OUT_LAST;
          blk_valid_o      <= 1'b1;
          blk_last_o       <= 1'b1;
        end
        S_OUT: if (blk_ready_i) begin
          buf_q       <= '0;
          blk_valid_o <= 1'b0;
          pad_pending <= 1'b0;
          len_pending <= 1'b0;
          wrapped     <= 1'b0;
          if (pad_pending) begin
            idx   <= '0;
            state <= S_PAD;
          end else if (len_pending) begin
            state <= S_LEN;
          end else begin
            state      <= S_LOAD;
            in_ready_o <= 1'b1;
          end
        end
        S_OUT_LAST: if (blk_ready_i) begin
          buf_q       <= '0;
          blk_valid_o <= 1'b0;
          blk_last_o  <= 1'b0;
          len         <= '0;
          idx         <= '0;
          state       <= S_LOAD;
          in_ready_o  <= 1'b1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef SHA_PAD_BLKCNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            blk_cnt_o <= '0;
    else if (blk_valid_o && blk_ready_i)  blk_cnt_o <= (state == S_OUT_LAST) ? 16'd0 : blk_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sha_256_pad.sv
// Bench for sha_256_pad: directed and random messages against a queue-based padding model.
module tb_sha_256_pad;
  typedef logic [7:0] byte_q[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] blk [0:15];
  logic        blk_valid, blk_last, blk_ready;
`ifdef SHA_PAD_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  int vecs = 0;
  int errs = 0;
  logic [511:0] exp_q[$];

  always #5 clk = ~clk;

  sha_256_pad dut (
    .clk_i(clk), .rst_i(rst),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .blk_o(blk), .blk_valid_o(blk_valid), .blk_last_o(blk_last), .blk_ready_i(blk_ready)
`ifdef SHA_PAD_BLKCNT_EN
    , .blk_cnt_o(blk_cnt)
`endif
  );

  function automatic logic [511:0] flat();
    logic [511:0] f;
    for (int w = 0; w < 16; w++) f[511-32*w -: 32] = blk[w];
    return f;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: FIPS 180-4 padding on a byte list, then sliced into 64-byte blocks.
  task automatic build(input byte_q msg);
    byte_q p;
    logic [63:0] bl;
    logic [511:0] b;
    exp_q.delete();
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    for (int i = 0; i < p.size(); i += 64) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[i+j];
      exp_q.push_back(b);
    end
  endtask

  task automatic send_bytes(input byte_q msg, input bit with_last);
    for (int i = 0; i < msg.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = with_last && (i == msg.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // stall < 0: random 0..3 cycles of backpressure per block.
  task automatic run_msg(input string tag, input byte_q msg, input int stall);
    int pos, bi, nblk, cyc, st;
    bit have_hold;
    logic [511:0] hold_v;
    build(msg);
    pos = 0; bi = 0; cyc = 0; have_hold = 0; hold_v = '0;
    nblk = exp_q.size();
    st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    while (bi < nblk && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (blk_valid) begin
        check({tag, "_in_ready_low"}, 512'(in_ready), 512'(0));
        if (have_hold) check({tag, "_hold"}, flat(), hold_v);
        if (st > 0) begin
          blk_ready = 1'b0;
          st--;
          have_hold = 1;
          hold_v = flat();
        end else begin
          blk_ready = 1'b1;
          check($sformatf("%s_blk%0d", tag, bi), flat(), exp_q[bi]);
          check($sformatf("%s_last%0d", tag, bi), 512'(blk_last), 512'(bi == nblk - 1));
`ifdef SHA_PAD_BLKCNT_EN
          check($sformatf("%s_cnt%0d", tag, bi), 512'(blk_cnt), 512'(bi));
`endif
          bi++;
          have_hold = 0;
          st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end
      end else begin
        blk_ready = 1'($urandom_range(0, 1));
        have_hold = 0;
      end
      if (!in_ready) begin
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'($urandom_range(0, 1));
      end else if (pos < msg.size()) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = msg[pos];
        in_last  = (pos == msg.size() - 1);
        if (in_valid) pos++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    if (bi < nblk) check({tag, "_timeout"}, 512'(bi), 512'(nblk));
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    check({tag, "_idle_valid"}, 512'(blk_valid), 512'(0));
    check({tag, "_idle_ready"}, 512'(in_ready), 512'(1));
`ifdef SHA_PAD_BLKCNT_EN
    check({tag, "_cnt_clr"}, 512'(blk_cnt), 512'(0));
`endif
  endtask

  initial begin
    byte_q msg, abc;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    #1;
    check("rst_in_ready", 512'(in_ready), 512'(1));
    check("rst_valid", 512'(blk_valid), 512'(0));
    check("rst_last", 512'(blk_last), 512'(0));
    check("rst_blk", flat(), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    // "abc" with timing: valid must rise after the second edge following the last byte
    abc = '{8'h61, 8'h62, 8'h63};
    build(abc);
    send_bytes(abc, 1'b1);
    check("abc_lat_t0", 512'(blk_valid), 512'(0));
    check("abc_rdy_t0", 512'(in_ready), 512'(0));
    @(negedge clk);
    check("abc_lat_t1", 512'(blk_valid), 512'(0));
    @(negedge clk);
    check("abc_lat_t2", 512'(blk_valid), 512'(1));
    check("abc_blk", flat(), exp_q[0]);
    check("abc_w0", 512'(blk[0]), 512'(32'h61626380));
    check("abc_w15", 512'(blk[15]), 512'(32'h18));
    check("abc_last", 512'(blk_last), 512'(1));
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check("abc_done_valid", 512'(blk_valid), 512'(0));
    check("abc_done_ready", 512'(in_ready), 512'(1));

    msg.delete(); for (int i = 0; i < 55; i++) msg.push_back(8'h00);
    run_msg("z55", msg, 0);
    msg.delete(); for (int i = 0; i < 56; i++) msg.push_back(8'h00);
    run_msg("z56", msg, 0);
    msg.delete(); for (int i = 0; i < 64; i++) msg.push_back(8'hFF);
    run_msg("ff64_bp", msg, 5);

    for (int t = 0; t < 8; t++) begin
      msg.delete();
      for (int i = 0; i < int'($urandom_range(1, 150)); i++) msg.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d", t), msg, -1);
    end

    // asynchronous reset after 20 bytes, checked before the next clock edge
    msg.delete(); for (int i = 0; i < 20; i++) msg.push_back(8'($urandom_range(1, 255)));
    send_bytes(msg, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_blk", flat(), 512'(0));
    check("mid_rst_ready", 512'(in_ready), 512'(1));
    check("mid_rst_valid", 512'(blk_valid), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset while a full block is held under backpressure
    msg.delete(); for (int i = 0; i < 64; i++) msg.push_back(8'hA5);
    send_bytes(msg, 1'b0);
    check("held_valid", 512'(blk_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    check("held_rst_valid", 512'(blk_valid), 512'(0));
    check("held_rst_blk", flat(), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    run_msg("abc_after_rst", abc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
